// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron and its synaptic front end:
// FSM state encoding, default widths and the saturating add used by the neuron.
package lif_pkg;

    // Default weight / current width and per-cycle trace leak.
    localparam int LIF_W           = 8;
    localparam int LIF_DECAY_SHIFT = 1;

    // Synapse FSM encoding; values are visible on the fsm_state debug port.
    typedef enum logic [1:0] {
        ST_CFG   = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } lif_state_e;

    // Unsigned add of two LIF_W-bit operands, clamped to all-ones on overflow.
    function automatic logic [LIF_W-1:0] sat_add(
        input logic [LIF_W-1:0] a,
        input logic [LIF_W-1:0] b
    );
        logic [LIF_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[LIF_W]) begin
            return '1;
        end
        return sum[LIF_W-1:0];
    endfunction

endpackage

// File: rtl/lif_weight_bank.sv
// N_IN x W weight register file: one write port, synchronous clear,
// all weights readable in parallel as a flat vector (synapse i at [i*W +: W]).
module lif_weight_bank #(
    parameter int N_IN = 4,
    parameter int W    = 8,
    parameter int AW   = $clog2(N_IN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [W-1:0]        wr_data,
    output logic [N_IN*W-1:0]   weights_flat
);

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_weight
            logic [W-1:0] weight_reg;

            // Each slot only responds to its own index, so addresses past
            // the last synapse match no slot and the write is dropped.
            always_ff @(posedge clk) begin
                if (rst) begin
                    weight_reg <= '0;
                end else if (wr_en && (int'(wr_addr) == gi)) begin
                    weight_reg <= wr_data;
                end
            end

            assign weights_flat[gi*W +: W] = weight_reg;
        end
    endgenerate

endmodule

// File: rtl/lif_synapse.sv
// Synaptic front end for the LIF neuron: per-input weights, a leaky trace
// that decays by a right shift each cycle, weighted spike accumulation with
// saturation, and a CFG/RUN/DRAIN controller gating weight updates.
module lif_synapse
    import lif_pkg::*;
#(
    parameter int N_IN        = 4,
    parameter int W           = lif_pkg::LIF_W,
    parameter int DECAY_SHIFT = lif_pkg::LIF_DECAY_SHIFT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_IN-1:0]         spikes_in,
    input  logic                    run_en,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [$clog2(N_IN)-1:0] cfg_addr,
    input  logic [W-1:0]            cfg_data,
    output logic [W-1:0]            current,
    output logic                    busy,
    output logic [1:0]              fsm_state
);

    localparam int AW    = $clog2(N_IN);
    // Wide enough for (trace >> shift) plus N_IN full-scale weights.
    localparam int SUM_W = W + $clog2(N_IN) + 1;

    lif_state_e         state_reg;
    lif_state_e         state_next;
    logic [W-1:0]       trace_reg;
    logic [W-1:0]       trace_next;

    logic [N_IN*W-1:0]  weights_flat;
    logic [SUM_W-1:0]   contrib [N_IN];
    logic [SUM_W-1:0]   sum_wide;
    logic [W-1:0]       trace_decay;
    logic [W-1:0]       trace_run;
    logic               weight_wr;

    // Weights may only change while the controller is idle in CFG.
    assign weight_wr = cfg_valid && (state_reg == ST_CFG);

    lif_weight_bank #(
        .N_IN (N_IN),
        .W    (W),
        .AW   (AW)
    ) u_weight_bank (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (weight_wr),
        .wr_addr      (cfg_addr),
        .wr_data      (cfg_data),
        .weights_flat (weights_flat)
    );

    // Gate each weight by its spike line, zero-extended to the sum width.
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_contrib
            assign contrib[gi] = spikes_in[gi]
                               ? SUM_W'(weights_flat[gi*W +: W])
                               : '0;
        end
    endgenerate

    assign trace_decay = trace_reg >> DECAY_SHIFT;

    // Leaked trace plus all active weights in one cycle.
    always_comb begin
        sum_wide = SUM_W'(trace_decay);
        for (int i = 0; i < N_IN; i++) begin
            sum_wide = sum_wide + contrib[i];
        end
    end

    // Clamp to the W-bit range so the trace can never wrap.
    always_comb begin
        if (|sum_wide[SUM_W-1:W]) begin
            trace_run = '1;
        end else begin
            trace_run = sum_wide[W-1:0];
        end
    end

    // Next-state and next-trace decode; RUN observing run_en low already
    // applies the drain update, and run_en in DRAIN beats the zero test.
    always_comb begin
        state_next = state_reg;
        trace_next = trace_reg;
        case (state_reg)
            ST_CFG: begin
                trace_next = '0;
                if (run_en) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (run_en) begin
                    trace_next = trace_run;
                end else begin
                    trace_next = trace_decay;
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                trace_next = trace_decay;
                if (run_en) begin
                    state_next = ST_RUN;
                end else if (trace_decay == '0) begin
                    state_next = ST_CFG;
                end
            end
            default: begin
                trace_next = '0;
                state_next = ST_CFG;
            end
        endcase
    end

    // State and trace registers; reset drops the trace with no drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_CFG;
            trace_reg <= '0;
        end else begin
            state_reg <= state_next;
            trace_reg <= trace_next;
        end
    end

    assign current   = trace_reg;
    assign cfg_ready = (state_reg == ST_CFG);
    assign busy      = (state_reg != ST_CFG);
    assign fsm_state = state_reg;

endmodule

// File: tb/tb_lif_synapse.sv
// Directed bench for lif_synapse (N_IN=4, W=8, DECAY_SHIFT=1) with
// hand-computed expected values; one line per transaction.
module tb_lif_synapse;

    logic       clk;
    logic       rst;
    logic [3:0] spikes_in;
    logic       run_en;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_data;
    logic [7:0] current;
    logic       busy;
    logic [1:0] fsm_state;

    int check_cnt = 0;
    int pass_cnt  = 0;

    lif_synapse #(
        .N_IN        (4),
        .W           (8),
        .DECAY_SHIFT (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .spikes_in (spikes_in),
        .run_en    (run_en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .current   (current),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int actual, input int expected);
        check_cnt++;
        if (actual == expected) begin
            pass_cnt++;
            $display("ok   %s: got %0d", tag, actual);
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [7:0] data);
        cfg_valid = 1'b1;
        cfg_addr  = addr;
        cfg_data  = data;
        step();
        cfg_valid = 1'b0;
    endtask

    int run_exp   [6] = '{10, 15, 17, 18, 19, 19};
    int drain1    [5] = '{9, 4, 2, 1, 0};
    int drain2    [4] = '{5, 2, 1, 0};
    int drain_sat [8] = '{127, 63, 31, 15, 7, 3, 1, 0};

    initial begin
        rst       = 1'b1;
        spikes_in = '0;
        run_en    = 1'b0;
        cfg_valid = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        step();
        step();
        chk("reset_current", current, 0);
        chk("reset_cfg_ready", cfg_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_state", fsm_state, 0);
        rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("idle%0d_current", i), current, 0);
            chk($sformatf("idle%0d_ready", i), cfg_ready, 1);
            chk($sformatf("idle%0d_busy", i), busy, 0);
        end

        // w0=10, w1=20, then enter RUN.
        cfg_write(2'd0, 8'd10);
        cfg_write(2'd1, 8'd20);
        run_en = 1'b1;
        step();
        chk("enter_run_state", fsm_state, 1);
        chk("enter_run_current", current, 0);
        chk("enter_run_ready", cfg_ready, 0);
        chk("enter_run_busy", busy, 1);

        // Spike input 0 every cycle while attempting a write of 99 to w0.
        spikes_in = 4'b0001;
        cfg_valid = 1'b1;
        cfg_addr  = 2'd0;
        cfg_data  = 8'd99;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("run_seq%0d", i), current, run_exp[i]);
        end
        cfg_valid = 1'b0;

        // Drop run_en: drain from 19 back to CFG.
        run_en    = 1'b0;
        spikes_in = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("drain1_%0d", i), current, drain1[i]);
            chk($sformatf("drain1_state%0d", i), fsm_state, (i == 4) ? 0 : 2);
        end
        chk("drain1_ready", cfg_ready, 1);

        // Spikes in CFG are ignored.
        spikes_in = 4'b0001;
        step();
        chk("cfg_spike_ignored", current, 0);

        // w0 must still be 10, not 99.
        run_en = 1'b1;
        step();
        chk("rerun_first_edge", current, 0);
        step();
        chk("w0_unchanged", current, 10);
        run_en    = 1'b0;
        spikes_in = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("drain2_%0d", i), current, drain2[i]);
        end
        chk("drain2_state", fsm_state, 0);

        // Saturation: all weights 200, all spikes.
        for (int i = 0; i < 4; i++) begin
            cfg_write(2'(i), 8'd200);
        end
        run_en = 1'b1;
        step();
        spikes_in = 4'b1111;
        step();
        chk("sat_all_spikes", current, 255);
        spikes_in = '0;
        step();
        chk("sat_decay", current, 127);
        spikes_in = 4'b1111;
        step();
        chk("sat_again", current, 255);

        // Drain from 255.
        run_en    = 1'b0;
        spikes_in = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("drain_sat%0d", i), current, drain_sat[i]);
            chk($sformatf("drain_sat_state%0d", i), fsm_state, (i == 7) ? 0 : 2);
        end
        chk("drain_sat_ready", cfg_ready, 1);

        // Reset while in RUN with current=100.
        cfg_write(2'd2, 8'd100);
        run_en = 1'b1;
        step();
        spikes_in = 4'b0100;
        step();
        chk("pre_reset_current", current, 100);
        rst       = 1'b1;
        run_en    = 1'b0;
        spikes_in = '0;
        step();
        rst = 1'b0;
        chk("mid_reset_current", current, 0);
        chk("mid_reset_state", fsm_state, 0);
        chk("mid_reset_ready", cfg_ready, 1);
        chk("mid_reset_busy", busy, 0);

        // Weights cleared by reset.
        run_en = 1'b1;
        step();
        spikes_in = 4'b1111;
        step();
        chk("weights_cleared", current, 0);
        chk("post_reset_run_state", fsm_state, 1);

        // run_en in DRAIN wins over the zero-trace exit.
        run_en    = 1'b0;
        spikes_in = '0;
        step();
        chk("drain_entry_state", fsm_state, 2);
        run_en = 1'b1;
        step();
        chk("drain_to_run_state", fsm_state, 1);
        chk("drain_to_run_busy", busy, 1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/lif_synapse.md
# lif_synapse

Synaptic front end for the LIF neuron. It converts up to N_IN binary input spike lines into the 8-bit `current` word the neuron integrates each cycle. It holds one programmable weight per input and keeps a leaky synaptic trace: every cycle the trace is shifted right by DECAY_SHIFT, the weights of all active inputs are added, and the result saturates to W bits. Weights are loaded through a valid/ready configuration port that is open only while the block is idle.

## Interface
- N_IN, 4, number of input spike lines (2..8)
- W, 8, weight and current width; must match the neuron's `current` width
- DECAY_SHIFT, 1, trace leak per cycle as a right shift (1..W-1)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- spikes_in  in  N_IN  input spikes, one bit per synapse, sampled every edge
- run_en  in  1  request to run; low requests drain and return to config
- cfg_valid  in  1  weight write request
- cfg_ready  out  1  high only in CFG state
- cfg_addr  in  $clog2(N_IN)  synapse index
- cfg_data  in  W  weight value, unsigned
- current  out  W  synaptic current to the neuron, registered
- busy  out  1  high in RUN or DRAIN
- fsm_state  out  2  CFG=0, RUN=1, DRAIN=2 (debug)

## Operation
- States: CFG, RUN, DRAIN.
- CFG:
  - cfg_ready=1; a write occurs when cfg_valid is high: weight[cfg_addr] <= cfg_data.
  - Addresses ≥ N_IN are accepted and discarded.
  - spikes_in ignored; trace held at 0.
  - run_en=1 → RUN. A write in the same cycle still commits.
- RUN:
  - trace_next = sat_W((trace >> DECAY_SHIFT) + Σ weight[i]·spikes_in[i]).
  - Sum width is W+$clog2(N_IN)+1 bits; saturates to 2^W-1. The trace never wraps.
  - run_en=0 → DRAIN. The cycle that observes run_en=0 already uses the DRAIN update.
  - cfg_valid ignored (cfg_ready=0); weights unchanged.
- DRAIN:
  - trace_next = trace >> DECAY_SHIFT; spikes_in ignored.
  - When trace_next == 0 → CFG.
  - run_en=1 → RUN, which takes priority over the zero test.
  - Drain length is at most ceil(W/DECAY_SHIFT) cycles.
- current = trace register, driven directly.
- busy = (state != CFG).
- The current output is always ≤ 2^W-1, so the neuron's unsigned add sees a bounded operand.

## Timing
- Reset (rst high at an edge):
  - state=CFG; all weights=0; trace=0.
  - Outputs: current=0, cfg_ready=1, busy=0, fsm_state=0.
  - Reset mid-RUN or mid-DRAIN discards the trace and weights immediately. There is no drain.
- Latency: spikes_in sampled at edge t appear in current after edge t (one cycle). The neuron's state reflects them one cycle later.
- cfg handshake: one write per cycle, no backpressure inside CFG. cfg_ready is a combinational decode of the state register.
- The CFG→RUN transition is one edge. The first spike sample that counts is the first edge taken in RUN.
- Simultaneous spikes on all inputs: all weights are summed in the same cycle.

## Structure
- Shared package (lif_pkg):
  - FSM state enum (CFG/RUN/DRAIN).
  - Default W and DECAY_SHIFT constants.
  - Saturating-add function reused by the neuron.
- One natural sub-module: lif_weight_bank. It is an N_IN×W register file with write port, reset and parallel read. The top keeps the FSM, adder tree, saturation and trace register.

## Test plan
- Reset, then hold all inputs 0 → current=0, cfg_ready=1, busy=0 for 10 cycles.
- Write w0=10, w1=20, then run_en=1; spike input 0 every cycle (DECAY_SHIFT=1) → current sequence 10, 15, 17, 18, 19, 19 (steady).
- w0..w3=200, all spikes high for 1 cycle → current=255 (saturated, not 800 mod 256). Next cycle with no spikes → 127.
- Trace=255, drop run_en → DRAIN: 127, 63, 31, 15, 7, 3, 1, 0, then CFG with cfg_ready=1.
- Write during RUN (cfg_valid=1, cfg_addr=0, data=99) → no write. Return to CFG and spike input 0 → contribution is the original weight.
- Assert rst while in RUN with current=100 → next cycle current=0, state CFG, all weights 0.
